// File: rtl/fifo_wr_ingress.sv
// fifo_wr_ingress
//   Write-side ingress stage in front of the async FIFO write-pointer
//   controller. A valid/ready packet stream is absorbed by a 2-entry skid
//   buffer and drained into the FIFO through we/wdata, gated by the
//   controller's registered full flag. While h_full is high (and
//   THROTTLE_EN=1) no new packet is started; packets already in flight
//   always complete. Word and packet write counters are maintained.
//
// Ports
//   wclk, w_rstn       write clock, synchronous active-low reset
//   s_valid, s_data,   upstream stream word, last-of-packet marker
//   s_last
//   s_ready            registered upstream ready
//   full, h_full       FIFO full / half-full flags
//   we, wdata          FIFO write enable and write data (head of buffer)
//   wr_count           words written to the FIFO (wraps)
//   pkt_count          packets whose last word was written (wraps)
//   throttle           high while new packets are being held off
module fifo_wr_ingress #(
    parameter int DATA_WIDTH  = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int THROTTLE_EN = 1
) (
    input  logic                  wclk,
    input  logic                  w_rstn,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic                  full,
    input  logic                  h_full,
    output logic                  we,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  throttle
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;

    // Slot 0 is always the head (oldest word); slot 1 is only valid when occ == 2.
    logic [DATA_WIDTH-1:0] data0;
    logic [DATA_WIDTH-1:0] data1;
    logic                  last0;
    logic                  last1;
    logic [1:0]            occ;
    logic [1:0]            occ_nxt;

    logic                  accept;
    logic                  pop;
    logic                  thr_req;
    logic                  ready_nxt;

    assign accept   = s_valid & s_ready;
    assign pop      = (occ != 2'd0) & ~full;
    assign thr_req  = (THROTTLE_EN != 0) & h_full;

    assign we       = pop;
    assign wdata    = (occ != 2'd0) ? data0 : '0;
    assign throttle = (state == WAIT);

    assign occ_nxt  = occ + {1'b0, accept} - {1'b0, pop};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (s_last) state_nxt = thr_req ? WAIT : IDLE;
                    else        state_nxt = PKT;
                end else if (thr_req) begin
                    state_nxt = WAIT;
                end
            end
            PKT: begin
                // h_full never interrupts a packet; only its last word can throttle.
                if (accept && s_last) state_nxt = thr_req ? WAIT : IDLE;
            end
            WAIT: begin
                if (!h_full) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is registered, so it must look at post-edge occupancy: a 1 here
    // guarantees a free slot for whatever is accepted next cycle.
    assign ready_nxt = (occ_nxt <= 2'd1) && (state_nxt != WAIT);

    always_ff @(posedge wclk) begin
        if (!w_rstn) begin
            state   <= IDLE;
            s_ready <= 1'b0;
        end else begin
            state   <= state_nxt;
            s_ready <= ready_nxt;
        end
    end

    always_ff @(posedge wclk) begin
        if (!w_rstn) begin
            occ   <= 2'd0;
            data0 <= '0;
            data1 <= '0;
            last0 <= 1'b0;
            last1 <= 1'b0;
        end else begin
            occ <= occ_nxt;
            if (pop) begin
                data0 <= data1;
                last0 <= last1;
            end
            // The incoming word lands at the tail of the post-pop contents;
            // this later assignment overrides the shift into slot 0 when needed.
            if (accept) begin
                if (occ_nxt == 2'd2) begin
                    data1 <= s_data;
                    last1 <= s_last;
                end else begin
                    data0 <= s_data;
                    last0 <= s_last;
                end
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (!w_rstn) begin
            wr_count  <= '0;
            pkt_count <= '0;
        end else if (pop) begin
            wr_count <= wr_count + CNT_WIDTH'(1);
            if (last0) pkt_count <= pkt_count + CNT_WIDTH'(1);
        end
    end

endmodule
